// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if: one data-bus link (request + response).
//   master modport : the side issuing requests (drives enables, address, write data/strobe;
//                    receives read data, waitreq stall and access_fault)
//   slave  modport : the side answering requests (mirror directions)
// waitreq carries the bus "wait" stall; the plain name is a reserved word.
interface dbus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strobe;
  logic [31:0]       rd_data;
  logic              waitreq;
  logic              access_fault;

  modport master (
    output rd_en, wr_en, addr, wr_data, wr_strobe,
    input  rd_data, waitreq, access_fault
  );

  modport slave (
    input  rd_en, wr_en, addr, wr_data, wr_strobe,
    output rd_data, waitreq, access_fault
  );
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master, one-slave data-bus arbiter with round-robin tie-break,
// zero-latency grant from IDLE, transfer locking while the slave stalls, and a
// stall timeout that forces a faulted completion.
//   clk : system clock, all state on rising edge
//   rst : asynchronous active-high reset
//   m0  : slave modport toward master 0 (core DBus port)
//   m1  : slave modport toward master 1 (secondary master)
//   s   : master modport toward the shared slave
module dbus_arbiter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  dbus_arbiter_if.slave  m0,
  dbus_arbiter_if.slave  m1,
  dbus_arbiter_if.master s
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q;
  logic            owner_q;
  logic            last_q;
  logic [CW-1:0]   cnt_q;

  logic            req0, req1;
  logic            grant_vld, grant_sel;
  logic            sel_rd, sel_wr;
  logic            illegal, timeout, done, fwd;
  logic [31:0]     resp_data;
  logic            resp_wait, resp_fault;

  always_comb begin
    req0      = m0.rd_en | m0.wr_en;
    req1      = m1.rd_en | m1.wr_en;
    grant_vld = 1'b0;
    grant_sel = 1'b0;

    // Reset holds off any grant so every slave-facing output reads zero.
    if (!rst) begin
      if (state_q == BUSY) begin
        // Locked to owner; owner dropping its request is an abort (no grant).
        grant_sel = owner_q;
        grant_vld = owner_q ? req1 : req0;
      end else if (req0 && req1) begin
        grant_vld = 1'b1;
        grant_sel = ~last_q;
      end else if (req0 || req1) begin
        grant_vld = 1'b1;
        grant_sel = req1;
      end
    end

    sel_rd  = grant_sel ? m1.rd_en : m0.rd_en;
    sel_wr  = grant_sel ? m1.wr_en : m0.wr_en;
    illegal = grant_vld & sel_rd & sel_wr;
    timeout = grant_vld & (state_q == BUSY) & (cnt_q == TMO) & s.waitreq;
    done    = grant_vld & (illegal | timeout | ~s.waitreq);
    fwd     = grant_vld & ~illegal & ~timeout;

    s.rd_en     = fwd & sel_rd;
    s.wr_en     = fwd & sel_wr;
    s.addr      = '0;
    s.wr_data   = '0;
    s.wr_strobe = '0;
    if (grant_vld) begin
      s.addr      = grant_sel ? m1.addr      : m0.addr;
      s.wr_data   = grant_sel ? m1.wr_data   : m0.wr_data;
      s.wr_strobe = grant_sel ? m1.wr_strobe : m0.wr_strobe;
    end

    // Forced completions (illegal request, timeout) return a bare fault.
    resp_data  = fwd ? s.rd_data : '0;
    resp_wait  = fwd & s.waitreq;
    resp_fault = (illegal | timeout) | (fwd & s.access_fault);

    m0.rd_data      = '0;
    m0.waitreq      = req0;
    m0.access_fault = 1'b0;
    m1.rd_data      = '0;
    m1.waitreq      = req1;
    m1.access_fault = 1'b0;
    if (grant_vld && !grant_sel) begin
      m0.rd_data      = resp_data;
      m0.waitreq      = resp_wait;
      m0.access_fault = resp_fault;
    end
    if (grant_vld && grant_sel) begin
      m1.rd_data      = resp_data;
      m1.waitreq      = resp_wait;
      m1.access_fault = resp_fault;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (done) begin
            last_q <= grant_sel;
          end else if (grant_vld) begin
            state_q <= BUSY;
            owner_q <= grant_sel;
            cnt_q   <= CW'(1);
          end
        end
        BUSY: begin
          if (!grant_vld) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (done) begin
            last_q  <= owner_q;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q != TMO) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
